// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo -- 8N1 UART receiver with a small receive buffer.
//
// The serial line is synchronized, then decoded by a bit-timing FSM.
// Received bytes land in a buffer that the consumer drains with a
// valid/ready handshake.
//
// Build option:
//   UART_RX_FIFO_EN defined   -> 4-entry FIFO
//   UART_RX_FIFO_EN undefined -> single holding register
//
// Parameters:
//   BAUD_DIV   clock cycles per bit (4..65535), default 104
//
// Ports:
//   clk        in   system clock
//   reset_n    in   asynchronous active-low reset
//   uart_rx    in   serial line, idle high, 8N1, LSB first
//   rx_data    out  byte at head of buffer
//   rx_valid   out  rx_data holds an unread byte
//   rx_ready   in   consumer accepts; pop on rx_valid && rx_ready
//   frame_err  out  one-cycle pulse on a bad stop bit
//   overrun    out  one-cycle pulse when a byte is dropped (buffer full)
module uart_rx_fifo #(
    parameter int BAUD_DIV = 104
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       uart_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

`ifdef UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    // Pointer width is kept >= 1 so the single-entry build still has a
    // well-formed index; the spare storage slot is simply never used.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(BAUD_DIV);

    localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(BAUD_DIV / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    // ---------------- synchronizer ----------------
    logic sync1_q, sync2_q, rxs;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= uart_rx;
            sync2_q <= sync1_q;
        end
    end

    assign rxs = sync2_q;

    // ---------------- receive FSM ----------------
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shreg_q, shreg_d;
    logic          push;
    logic          ferr_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        push    = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxs) state_d = START;
            end
            START: begin
                // Re-check the line half a bit in; a high line here was a glitch.
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DATA: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d          = '0;
                    shreg_d[idx_q] = rxs;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            STOP: begin
                if (cnt_q == CNT_FULL) begin
                    cnt_d = '0;
                    if (rxs) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            WAIT_HIGH: begin
                // A held-low line (break) must not start a new frame.
                cnt_d = '0;
                if (rxs) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------- receive buffer ----------------
    logic [7:0]    mem_q [2**PW];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [2:0]    count_q, count_d;
    logic          full, pop, accept, overrun_d;
    logic          frame_err_q, overrun_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full      = (count_q == 3'(DEPTH));
    assign pop       = rx_valid && rx_ready;
    // A pop in the same cycle frees the head slot, so a full buffer can accept.
    assign accept    = push && (!full || pop);
    assign overrun_d = push && full && !pop;

    always_comb begin
        count_d = count_q;
        if (accept && !pop)      count_d = count_q + 3'd1;
        else if (!accept && pop) count_d = count_q - 3'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2**PW; i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if (accept) begin
                mem_q[wr_ptr_q] <= shreg_q;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q     <= count_d;
            frame_err_q <= ferr_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_valid  = (count_q != 3'd0);
    assign rx_data   = mem_q[rd_ptr_q];
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule
